// File: rtl/common.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Machine-wide base types shared by every pipeline stage.
//               creg_addr_t - architectural register index (x0..x31)
//               word_t      - 64-bit datapath word
// Revision    : 1.0 - initial release
// ============================================================================
package common;
    localparam int c_num_cregs = 32;
    localparam int c_xlen      = 64;

    typedef logic [$clog2(c_num_cregs)-1:0] creg_addr_t;
    typedef logic [c_xlen-1:0]              word_t;
endpackage
`default_nettype wire

// File: rtl/pipes.sv
`default_nettype none
// ============================================================================
// Module      : pipes (package)
// Description : Types shared between pipeline stages.
//               busy_vec_t - one in-flight-producer bit per architectural reg
// Revision    : 1.0 - initial release
// ============================================================================
package pipes;
    import common::*;

    typedef logic [c_num_cregs-1:0] busy_vec_t;
endpackage
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : 32 x 64-bit integer register file with two combinational read
//               ports, one writeback port, optional write-to-read forwarding
//               and an inline busy-bit scoreboard for decode-stage hazards.
//
// Ports
//   clk          in   clock, all state updates on rising edge
//   resetn       in   asynchronous active-low reset (clears regs and busy)
//   ra1, ra2     in   decode read addresses
//   rd1, rd2     out  read data (x0 reads 0, forwarded when BYPASS=1)
//   busy1, busy2 out  read address has an outstanding in-flight producer
//   wvalid       in   writeback enable
//   wa, wd       in   writeback destination / data
//   issue_valid  in   decode issues an instruction writing issue_dst
//   issue_dst    in   destination of the issued instruction
//   flush        in   clears every busy bit (register contents kept)
//
// Parameters
//   BYPASS       1 = same-cycle writeback forwarded to reads, 0 = stored only
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import common::*;
    import pipes::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    output word_t      rd1,
    output word_t      rd2,
    output logic       busy1,
    output logic       busy2,
    input  logic       wvalid,
    input  creg_addr_t wa,
    input  word_t      wd,
    input  logic       issue_valid,
    input  creg_addr_t issue_dst,
    input  logic       flush
);

    word_t     r_regs [c_num_cregs];
    busy_vec_t r_busy;
    busy_vec_t w_busy_next;
    logic      w_fwd1;
    logic      w_fwd2;

    // Clear first, then set: an instruction issuing to the register that is
    // retiring this cycle is the newer producer and must keep it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (wvalid) begin
            w_busy_next[wa] = 1'b0;
        end
        if (issue_valid && (issue_dst != '0)) begin
            w_busy_next[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < c_num_cregs; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            // Writes commit regardless of flush; x0 is never stored.
            if (wvalid && (wa != '0)) begin
                r_regs[wa] <= wd;
            end
            r_busy <= flush ? '0 : w_busy_next;
        end
    end

    // A producer completing this cycle both supplies the data and releases
    // the stall, so forwarding and busy suppression share one match term.
    assign w_fwd1 = BYPASS && wvalid && (wa == ra1);
    assign w_fwd2 = BYPASS && wvalid && (wa == ra2);

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = w_fwd1 ? wd : r_regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = w_fwd2 ? wd : r_regs[ra2];
        end
    end

    assign busy1 = (ra1 != '0) && r_busy[ra1] && !w_fwd1;
    assign busy2 = (ra2 != '0) && r_busy[ra2] && !w_fwd2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. Two instances share all
//               inputs: one with forwarding, one without. A directed vector
//               table and hand-written sequences cover the corner cases, then
//               random traffic is compared against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import common::*;
    import pipes::*;

    logic       clk = 1'b0;
    logic       resetn;
    creg_addr_t ra1, ra2, wa, issue_dst;
    word_t      wd;
    logic       wvalid, issue_valid, flush;
    word_t      rd1, rd2, rd1_nb, rd2_nb;
    logic       busy1, busy2, busy1_nb, busy2_nb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1'b1)) dut (
        .clk(clk), .resetn(resetn), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .wvalid(wvalid), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .flush(flush)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .resetn(resetn), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .wvalid(wvalid), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .flush(flush)
    );

    // ---------------- reference model ----------------
    word_t m_regs [32];
    bit    m_busy [32];

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_edge();
        if (!resetn) begin
            m_clear();
        end else begin
            if (wvalid && wa != 0) m_regs[wa] = wd;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (wvalid) m_busy[wa] = 1'b0;
                if (issue_valid && issue_dst != 0) m_busy[issue_dst] = 1'b1;
            end
        end
    endtask

    function automatic word_t m_rd(creg_addr_t a, bit byp);
        if (a == 0) return '0;
        if (byp && wvalid && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_bz(creg_addr_t a, bit byp);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(byp && wvalid && wa == a);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string nm, word_t act, word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " rd1"},      rd1,              m_rd(ra1, 1'b1));
        chk({tag, " rd2"},      rd2,              m_rd(ra2, 1'b1));
        chk({tag, " busy1"},    {63'b0, busy1},   {63'b0, m_bz(ra1, 1'b1)});
        chk({tag, " busy2"},    {63'b0, busy2},   {63'b0, m_bz(ra2, 1'b1)});
        chk({tag, " rd1_nb"},   rd1_nb,           m_rd(ra1, 1'b0));
        chk({tag, " rd2_nb"},   rd2_nb,           m_rd(ra2, 1'b0));
        chk({tag, " busy1_nb"}, {63'b0, busy1_nb},{63'b0, m_bz(ra1, 1'b0)});
        chk({tag, " busy2_nb"}, {63'b0, busy2_nb},{63'b0, m_bz(ra2, 1'b0)});
    endtask

    task automatic idle();
        wvalid = 1'b0; wa = '0; wd = '0;
        issue_valid = 1'b0; issue_dst = '0; flush = 1'b0;
    endtask

    // Inputs already applied; check mid-cycle, then clock and update model.
    task automatic step(string tag, bit do_check);
        @(negedge clk);
        if (do_check) check_model(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Sweep every address with no edge dependence; inputs must be idle.
    task automatic sweep_zero(string tag);
        for (int a = 0; a < 32; a++) begin
            ra1 = creg_addr_t'(a);
            ra2 = creg_addr_t'(31 - a);
            #1;
            chk({tag, " rd1"},   rd1,            64'd0);
            chk({tag, " rd2"},   rd2,            64'd0);
            chk({tag, " busy1"}, {63'b0, busy1}, 64'd0);
            chk({tag, " busy2"}, {63'b0, busy2}, 64'd0);
            chk({tag, " rd1_nb"}, rd1_nb,        64'd0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       wv;
        creg_addr_t wa;
        word_t      wd;
        logic       iv;
        creg_addr_t id;
        creg_addr_t a1;
        creg_addr_t a2;
        word_t      e1;
        word_t      e2;
        logic       b1;
        logic       b2;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Applied in order from reset; expectations for the forwarding DUT.
        tbl[0] = '{1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0, 5'd5, 5'd0, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd0, 64'hFF,                  1'b0, 5'd0, 5'd5, 5'd0, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 64'd0,                   1'b1, 5'd3, 5'd3, 5'd5, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 64'd0,                   1'b0, 5'd0, 5'd3, 5'd3, 64'd0, 64'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 5'd3, 64'h33,                  1'b0, 5'd0, 5'd3, 5'd3, 64'h33, 64'h33, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 64'd0,                   1'b0, 5'd0, 5'd3, 5'd0, 64'h33, 64'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd9, 64'h99,                  1'b1, 5'd9, 5'd9, 5'd0, 64'h99, 64'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 64'd0,                   1'b0, 5'd0, 5'd9, 5'd0, 64'h99, 64'd0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 5'd7, 64'h55,                  1'b0, 5'd0, 5'd0, 5'd7, 64'd0, 64'h55, 1'b0, 1'b0};

        idle();
        ra1 = '0; ra2 = '0;
        resetn = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        sweep_zero("reset");

        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            wvalid = tbl[i].wv; wa = tbl[i].wa; wd = tbl[i].wd;
            issue_valid = tbl[i].iv; issue_dst = tbl[i].id; flush = 1'b0;
            ra1 = tbl[i].a1; ra2 = tbl[i].a2;
            @(negedge clk);
            chk($sformatf("vec%0d rd1", i),   rd1,            tbl[i].e1);
            chk($sformatf("vec%0d rd2", i),   rd2,            tbl[i].e2);
            chk($sformatf("vec%0d busy1", i), {63'b0, busy1}, {63'b0, tbl[i].b1});
            chk($sformatf("vec%0d busy2", i), {63'b0, busy2}, {63'b0, tbl[i].b2});
            @(posedge clk);
            m_edge();
            #1;
        end

        // Forwarding versus stored-only read of x7 (holds 0x55).
        idle();
        wvalid = 1'b1; wa = 5'd7; wd = 64'h77;
        ra1 = 5'd0; ra2 = 5'd7;
        @(negedge clk);
        chk("bypass rd2", rd2, 64'h77);
        chk("nobypass rd2", rd2_nb, 64'h55);
        @(posedge clk);
        m_edge();
        #1;

        // Flush: busy x1, x2, x4, then flush with a write to x4 and an issue.
        idle();
        foreach (tbl[k]) begin end
        issue_valid = 1'b1; issue_dst = 5'd1; step("iss1", 1'b1);
        issue_dst = 5'd2; step("iss2", 1'b1);
        issue_dst = 5'd4; step("iss4", 1'b1);
        idle();
        ra1 = 5'd1; ra2 = 5'd2; #1;
        chk("pre-flush busy x1", {63'b0, busy1}, 64'd1);
        chk("pre-flush busy x2", {63'b0, busy2}, 64'd1);
        ra1 = 5'd4; #1;
        chk("pre-flush busy x4", {63'b0, busy1}, 64'd1);
        flush = 1'b1; wvalid = 1'b1; wa = 5'd4; wd = 64'h11;
        issue_valid = 1'b1; issue_dst = 5'd6;
        step("flush", 1'b0);
        idle();
        for (int a = 0; a < 32; a++) begin
            ra1 = creg_addr_t'(a); #1;
            chk($sformatf("post-flush busy x%0d", a), {63'b0, busy1}, 64'd0);
        end
        ra1 = 5'd4; ra2 = 5'd5; #1;
        chk("post-flush x4", rd1, 64'h11);
        chk("post-flush x5", rd2, 64'hDEAD_BEEF_0123_4567);

        // Async reset between edges: state clears with no clock edge.
        issue_valid = 1'b1; issue_dst = 5'd5; step("iss5", 1'b1);
        idle();
        @(negedge clk);
        #1;
        resetn = 1'b0;
        m_clear();
        ra1 = 5'd5; ra2 = 5'd4; #1;
        chk("async rst x5", rd1, 64'd0);
        chk("async rst x4", rd2, 64'd0);
        chk("async rst busy x5", {63'b0, busy1}, 64'd0);
        sweep_zero("async");

        // Write and issue while reset is held are discarded.
        wvalid = 1'b1; wa = 5'd12; wd = 64'h1234; issue_valid = 1'b1; issue_dst = 5'd12;
        @(posedge clk);
        #1;
        idle();
        ra1 = 5'd12; #1;
        chk("rst discards write", rd1, 64'd0);
        chk("rst discards issue", {63'b0, busy1}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            wvalid      = ($urandom_range(0, 99) < 50);
            wa          = ($urandom_range(0, 1) == 0) ? creg_addr_t'($urandom_range(0, 7)) : creg_addr_t'($urandom_range(0, 31));
            wd          = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 99) < 50);
            issue_dst   = ($urandom_range(0, 1) == 0) ? creg_addr_t'($urandom_range(0, 7)) : creg_addr_t'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 99) < 4);
            ra1         = ($urandom_range(0, 1) == 0) ? creg_addr_t'($urandom_range(0, 7)) : creg_addr_t'($urandom_range(0, 31));
            ra2         = ($urandom_range(0, 3) == 0) ? ra1 : creg_addr_t'($urandom_range(0, 7));
            step($sformatf("rand%0d", c), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
